truth_table_sequencer: RTL and testbench
========================================

// Module: truth_table_sequencer
// PURPOSE
//   Sequences a 3-input single-output logic circuit through all 8 input rows.
//   Each row is held for a programmable settle time, then the circuit output is
//   sampled into an 8-bit truth-table word. The word is compared against an
//   expected hex code, for example 8'hBC.
//   Sits between the test/characterisation harness and the circuit under
//   evaluation, and drives in1/in2/in3 on the circuit's behalf.
// PARAMETERS
//   SETTLE_CYCLES  16     clocks each row is held before sampling (>=1)
//   CNT_W          8      settle counter width; must hold SETTLE_CYCLES
//   EXPECTED       8'hBC  expected truth table; bit (7-r) = out for row r={in1,in2,in3}
// PORTS
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  one-cycle request to run a full 8-row sweep
//   abort      in   1  cancel sweep; highest priority after reset
//   dut_out    in   1  output of the circuit under evaluation
//   in1        out  1  circuit input MSB, registered
//   in2        out  1  circuit input, registered
//   in3        out  1  circuit input LSB, registered
//   row_idx    out  3  row currently applied, {in1,in2,in3}
//   busy       out  1  sweep in progress
//   done       out  1  sweep complete; held until next accepted start
//   pass       out  1  valid when done: table_out == EXPECTED
//   table_out  out  8  captured truth table, MSB = row 0
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; in1..3=0; row_idx=0; busy=0; done=0;
//     pass=0; table_out=8'h00; settle count=0. Release is synchronous to clk.
//   FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
//   IDLE or DONE + start=1 -> APPLY next cycle.
//     - Clears row_idx, table_out, done and pass; sets busy.
//   APPLY: registers {in1,in2,in3}=row_idx and loads counter=SETTLE_CYCLES-1.
//     - Goes to SETTLE.
//   SETTLE: decrements counter each cycle; at 0 goes to SAMPLE.
//   SAMPLE: table_out[7-row_idx] <= dut_out.
//     - If row_idx==7: go to DONE. busy=0, done=1, and in the same edge
//       pass = (final table == EXPECTED); include the bit sampled this cycle.
//     - Otherwise: row_idx += 1 and go to APPLY.
//   Row timing: 1 APPLY + SETTLE_CYCLES + 1 SAMPLE clocks per row.
//     - Full sweep = 8*(SETTLE_CYCLES+2) clocks from the start edge to done=1.
//     - Inputs change only on APPLY edges, so they are glitch-free within a row.
//   start while busy: ignored, with no effect on the sweep.
//   abort=1 in any state -> IDLE next cycle.
//     - busy=0, done=0, pass=0, in1..3=0; table_out keeps its partial value.
//     - abort and start in the same cycle: abort wins.
//   row_idx wrap: never increments past 7; the sweep ends at 7.
//   dut_out is sampled only in SAMPLE; its value in other states is don't-care.
//   Reset mid-sweep: immediate return to reset values; no partial done.
// STRUCTURE
//   Package truth_table_pkg:
//     - state enum tt_state_e {IDLE, APPLY, SETTLE, SAMPLE, DONE}
//     - localparam NUM_ROWS=8, ROW_W=3
//   Sub-module settle_timer:
//     - inputs: load, load_val[CNT_W-1:0], en
//     - output: expired
//     - counts down; same clk/rst_n
//   Top holds the FSM, row counter, input registers, capture shift/insert
//   logic and the comparator.
// TESTING
//   1. Reset with rst_n=0 mid-sweep -> all outputs at reset values on the same
//      cycle; busy=0, table_out=00.
//   2. SETTLE_CYCLES=4, behavioural circuit implementing 8'hBC, pulse start.
//      - done=1 exactly 48 clocks after the start edge.
//      - table_out=8'hBC, pass=1.
//      - in1..3 step through 000..111, each held 6 clocks.
//   3. Same bench, circuit implementing 8'hBD.
//      - table_out=8'hBD, pass=0, done=1.
//   4. Pulse start again at row 3 while busy.
//      - Sweep unaffected; done still lands at clock 48; table_out=8'hBC.
//   5. abort at row 5 SETTLE.
//      - Next cycle IDLE, busy=0, done=0, in=000.
//      - A new start then completes normally with pass=1.
//   6. abort and start asserted together in IDLE -> stays IDLE, busy=0.

Source files
------------

// File: rtl/truth_table_pkg.sv
// Shared types and sizes for the truth-table sequencer.
// The sequencer walks the 3-input rows of a circuit and captures one output bit per row.
package truth_table_pkg;

  localparam int NUM_ROWS = 8;
  localparam int ROW_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } tt_state_e;

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Down-counter that measures how long each row is held before sampling.
// expired is high whenever the count has reached zero.
module settle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // The count saturates at zero, so a stray enable cannot wrap it around.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Drives in1/in2/in3 through all eight rows, samples dut_out after each settle window,
// and compares the captured truth table against EXPECTED.
module truth_table_sequencer
  import truth_table_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8,
  parameter logic [7:0]  EXPECTED      = 8'hBC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic [2:0] row_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] table_out
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  tt_state_e        state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] in_q, in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [7:0]       table_q, table_d;

  logic             timer_load;
  logic             timer_en;
  logic             timer_expired;
  logic [ROW_W-1:0] sample_idx;

  settle_timer #(
    .CNT_W(CNT_W)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .load_val(SETTLE_LOAD),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Row 0 lands in the MSB of the table.
  assign sample_idx = LAST_ROW - row_q;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    in_d       = in_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    table_d    = table_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      in_d    = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = APPLY;
            row_d   = '0;
            table_d = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
        APPLY: begin
          in_d       = row_q;
          timer_load = 1'b1;
          state_d    = SETTLE;
        end
        SETTLE: begin
          if (timer_expired) begin
            state_d = SAMPLE;
          end else begin
            timer_en = 1'b1;
          end
        end
        SAMPLE: begin
          table_d[sample_idx] = dut_out;
          // Verdict uses the table including the bit captured on this edge.
          if (row_q == LAST_ROW) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (table_d == EXPECTED);
          end else begin
            row_d   = row_q + 1'b1;
            state_d = APPLY;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      in_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      table_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      in_q    <= in_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      table_q <= table_d;
    end
  end

  assign in1       = in_q[2];
  assign in2       = in_q[1];
  assign in3       = in_q[0];
  assign row_idx   = row_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign table_out = table_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer with SETTLE_CYCLES=4 and a behavioural
// 3-input circuit whose truth table is held in 'code' (bit 7-r is the output for row r).
module tb_truth_table_sequencer;

  localparam int SETTLE   = 4;
  localparam int ROW_CLKS = SETTLE + 2;
  localparam int SWEEP    = 8 * ROW_CLKS;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       dut_out;
  logic       in1;
  logic       in2;
  logic       in3;
  logic [2:0] row_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] table_out;
  logic [7:0] code;
  logic [2:0] row_in;

  int checks = 0;
  int errors = 0;

  truth_table_sequencer #(
    .SETTLE_CYCLES(SETTLE),
    .CNT_W        (8),
    .EXPECTED     (8'hBC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .dut_out  (dut_out),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .row_idx  (row_idx),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .table_out(table_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural circuit under evaluation.
  assign row_in  = {in1, in2, in3};
  assign dut_out = code[3'd7 - row_in];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    code  = 8'hBC;
    tick();
    tick();
    checks++;
    if ({busy, done, pass, row_in, row_idx, table_out} !== 17'h0) begin
      errors++;
      $display("[TB] FAIL reset_values: busy=%b done=%b pass=%b in=%b row=%0d table=%h, required all zero",
               busy, done, pass, row_in, row_idx, table_out);
    end
    rst_n = 1'b1;
    tick();
    // Start a sweep and hit reset after rows 0..2 have been captured.
    pulse_start();
    for (int n = 1; n <= 20; n++) tick();
    checks++;
    if (table_out !== 8'hA0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_partial: table=%h busy=%b, required table=a0 busy=1", table_out, busy);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({busy, done, pass, row_in, row_idx, table_out} !== 17'h0) begin
      errors++;
      $display("[TB] FAIL midsweep_reset: busy=%b done=%b pass=%b in=%b row=%0d table=%h, required all zero",
               busy, done, pass, row_in, row_idx, table_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  // Full sweep; restart_at > 0 re-pulses start on that clock while busy.
  task automatic test_sweep(input string name, input logic [7:0] c, input logic [7:0] exp_table,
                            input logic exp_pass, input int restart_at);
    int seq_bad;
    int early;
    logic [2:0] exp_in;
    logic [2:0] exp_row;
    seq_bad = 0;
    early   = 0;
    code    = c;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || row_idx !== 3'd0 || table_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL %s start_clears: busy=%b done=%b pass=%b row=%0d table=%h, required 1 0 0 0 00",
               name, busy, done, pass, row_idx, table_out);
    end
    for (int n = 1; n <= SWEEP; n++) begin
      if (n == restart_at) start = 1'b1;
      tick();
      start   = 1'b0;
      exp_in  = 3'((n - 1) / ROW_CLKS);
      exp_row = (n >= SWEEP) ? 3'd7 : 3'(n / ROW_CLKS);
      if (row_in !== exp_in || row_idx !== exp_row) seq_bad++;
      if (n < SWEEP && (done !== 1'b0 || busy !== 1'b1)) early++;
    end
    checks++;
    if (seq_bad != 0) begin
      errors++;
      $display("[TB] FAIL %s in_row_sequence: %0d bad cycles, required 0", name, seq_bad);
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("[TB] FAIL %s busy_done_during_sweep: %0d bad cycles, required 0", name, early);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s done_at_%0d: done=%b busy=%b, required 1 0", name, SWEEP, done, busy);
    end
    checks++;
    if (table_out !== exp_table) begin
      errors++;
      $display("[TB] FAIL %s table_out: got %h, required %h", name, table_out, exp_table);
    end
    checks++;
    if (pass !== exp_pass) begin
      errors++;
      $display("[TB] FAIL %s pass: got %b, required %b", name, pass, exp_pass);
    end
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || table_out !== exp_table) begin
      errors++;
      $display("[TB] FAIL %s done_held: done=%b table=%h, required 1 %h", name, done, table_out, exp_table);
    end
  endtask

  task automatic test_abort();
    code = 8'hBC;
    pulse_start();
    // After clock 32 row 5 is in SETTLE.
    for (int n = 1; n <= 32; n++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || row_in !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_outputs: busy=%b done=%b pass=%b in=%b, required 0 0 0 000",
               busy, done, pass, row_in);
    end
    checks++;
    if (table_out !== 8'hB8) begin
      errors++;
      $display("[TB] FAIL abort_partial_table: got %h, required b8", table_out);
    end
    for (int n = 0; n < 10; n++) tick();
    checks++;
    if (busy !== 1'b0 || row_in !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_stays_idle: busy=%b in=%b, required 0 000", busy, row_in);
    end
    test_sweep("after_abort", 8'hBC, 8'hBC, 1'b1, 0);
  endtask

  task automatic test_abort_and_start();
    // Leave DONE through abort first, then try start+abort together in IDLE.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (done !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_from_done: done=%b pass=%b, required 0 0", done, pass);
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || row_in !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_beats_start: busy=%b done=%b in=%b, required 0 0 000", busy, done, row_in);
    end
  endtask

  initial begin
    test_reset();
    test_sweep("sweep_bc", 8'hBC, 8'hBC, 1'b1, 0);
    test_sweep("sweep_bd", 8'hBD, 8'hBD, 1'b0, 0);
    test_sweep("back_to_back_start", 8'hBC, 8'hBC, 1'b1, 20);
    test_abort();
    test_abort_and_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
